// File: rtl/bilinear_scale_down.sv
// Frame-based bilinear resampler: fetches source line pairs from DDR into two line
// buffers and emits one interpolated 16-bit pixel per cycle in raster order.
module bilinear_scale_down #(
    parameter int MAX_XRES = 2048,
    parameter int FRAC_W   = 8
) (
    input  logic        vin_clk,
    input  logic        rst_n,
    input  logic        frame_sync_n,
    input  logic [15:0] vin_xres,
    input  logic [15:0] vin_yres,
    input  logic [15:0] vout_xres,
    input  logic [15:0] vout_yres,
    input  logic        ddr_ready,
    output logic        fetch_en,
    output logic [15:0] fetch_line,
    input  logic        wr_ram_en,
    input  logic [15:0] ram_dat,
    input  logic        fetch_done,
    output logic        vout_wr_valid,
    output logic [15:0] vout_wr_x,
    output logic [15:0] vout_wr_y,
    output logic [15:0] vout_wr_dat
);
    localparam int AW = $clog2(MAX_XRES);
    localparam int HW = 17 + FRAC_W;
    localparam int VW = HW + FRAC_W + 1;
    localparam logic [FRAC_W:0] ONE  = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [VW:0]     HALF = (VW+1)'(1) << (2*FRAC_W - 1);

    typedef enum logic [2:0] {IDLE, DIV, REQ, LOAD, CALC, DONE} state_t;
    state_t state, state_nx;

    logic        clr;
    logic [15:0] xres, yres, oxres, oyres;
    logic [31:0] rx, ry, dq, dq_nx;
    logic [15:0] rem, rem_nx, dvs;
    logic [16:0] trial;
    logic        ge;
    logic [4:0]  div_cnt;
    logic        div_sel;
    logic [47:0] sx_acc, sy_acc, sy_nx;
    logic [15:0] ox, oy, wcol, buf_line;
    logic        wsel, wfull, buf_ok;
    logic [15:0] ylim, xlim, iy, iy_nx, ix;
    logic [AW-1:0] ix1;
    logic        y_clamp, last_px, more_rows, reuse_nx;
    logic [FRAC_W-1:0] fx, fy;

    logic [15:0] top_mem [MAX_XRES];
    logic [15:0] bot_mem [MAX_XRES];

    logic              v1, v2;
    logic [15:0]       p00, p01, p10, p11, x1, y1, x2, y2;
    logic [FRAC_W-1:0] fx1, fy1, fy2;
    logic [FRAC_W:0]   wx0, wy0;
    logic [HW-1:0]     h0, h1, h0_c, h1_c;
    logic [VW-1:0]     v_c;
    logic [VW:0]       rnd, sh;
    logic [15:0]       dat_c;

    assign clr = !rst_n || !frame_sync_n;

    // Source mapping; the y side also looks one row ahead to decide pair reuse.
    always_comb begin
        ylim      = yres - 16'd2;
        y_clamp   = sy_acc[47:16] > {16'h0, ylim};
        iy        = y_clamp ? ylim : sy_acc[31:16];
        fy        = y_clamp ? '1 : sy_acc[15 -: FRAC_W];
        sy_nx     = sy_acc + {16'h0, ry};
        iy_nx     = (sy_nx[47:16] > {16'h0, ylim}) ? ylim : sy_nx[31:16];
        xlim      = xres - 16'd1;
        ix        = (sx_acc[47:16] > {16'h0, xlim}) ? xlim : sx_acc[31:16];
        ix1       = (ix == xlim) ? ix[AW-1:0] : ix[AW-1:0] + AW'(1);
        fx        = sx_acc[15 -: FRAC_W];
        last_px   = (ox == oxres - 16'd1);
        more_rows = (17'(oy) + 17'd1) < 17'(oyres);
        reuse_nx  = buf_ok && (buf_line == iy_nx);
    end

    always_comb begin
        dvs    = div_sel ? oyres : oxres;
        trial  = {rem, dq[31]};
        ge     = trial >= {1'b0, dvs};
        rem_nx = 16'(ge ? trial - {1'b0, dvs} : trial);
        dq_nx  = {dq[30:0], ge};
    end

    always_ff @(posedge vin_clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        fetch_en   = 1'b0;
        fetch_line = '0;
        case (state)
            IDLE: if (ddr_ready) state_nx = DIV;
            DIV:  if (div_sel && div_cnt == 5'd31) state_nx = REQ;
            REQ: begin
                fetch_en   = 1'b1;
                fetch_line = iy;
                state_nx   = LOAD;
            end
            LOAD: if (fetch_done) state_nx = CALC;
            CALC: if (last_px) begin
                if (!more_rows)    state_nx = DONE;
                else if (reuse_nx) state_nx = CALC;
                else               state_nx = REQ;
            end
            DONE: if (!v1 && !v2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge vin_clk) begin
        if (clr) begin
            xres <= '0; yres <= '0; oxres <= '0; oyres <= '0;
            rx <= '0; ry <= '0; dq <= '0; rem <= '0;
            div_cnt <= '0; div_sel <= 1'b0;
            sx_acc <= '0; sy_acc <= '0; ox <= '0; oy <= '0;
            wcol <= '0; wsel <= 1'b0; wfull <= 1'b0;
            buf_ok <= 1'b0; buf_line <= '0;
        end else begin
            case (state)
                IDLE: if (ddr_ready) begin
                    xres <= vin_xres; yres <= vin_yres;
                    oxres <= vout_xres; oyres <= vout_yres;
                    dq <= {vin_xres, 16'h0}; rem <= '0;
                    div_cnt <= '0; div_sel <= 1'b0; buf_ok <= 1'b0;
                    sx_acc <= '0; sy_acc <= '0; ox <= '0; oy <= '0;
                end
                DIV: begin
                    rem     <= rem_nx;
                    dq      <= dq_nx;
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        if (!div_sel) begin
                            rx      <= dq_nx;
                            dq      <= {yres, 16'h0};
                            rem     <= '0;
                            div_sel <= 1'b1;
                        end else begin
                            ry <= dq_nx;
                        end
                    end
                end
                REQ: begin
                    wcol <= '0; wsel <= 1'b0; wfull <= 1'b0;
                end
                LOAD: begin
                    if (wr_ram_en && !wfull) begin
                        if (wcol == xlim) begin
                            wcol <= '0;
                            if (wsel) wfull <= 1'b1;
                            else      wsel  <= 1'b1;
                        end else begin
                            wcol <= wcol + 16'd1;
                        end
                    end
                    if (fetch_done) begin
                        buf_ok   <= 1'b1;
                        buf_line <= iy;
                    end
                end
                CALC: begin
                    if (last_px) begin
                        ox <= '0; sx_acc <= '0;
                        oy <= oy + 16'd1; sy_acc <= sy_nx;
                    end else begin
                        ox <= ox + 16'd1;
                        sx_acc <= sx_acc + {16'h0, rx};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge vin_clk) begin
        if (!clr && state == LOAD && wr_ram_en && !wfull) begin
            if (wsel) bot_mem[wcol[AW-1:0]] <= ram_dat;
            else      top_mem[wcol[AW-1:0]] <= ram_dat;
        end
    end

    always_comb begin
        wx0   = ONE - {1'b0, fx1};
        wy0   = ONE - {1'b0, fy2};
        h0_c  = HW'(p00) * HW'(wx0) + HW'(p01) * HW'(fx1);
        h1_c  = HW'(p10) * HW'(wx0) + HW'(p11) * HW'(fx1);
        v_c   = VW'(h0) * VW'(wy0) + VW'(h1) * VW'(fy2);
        rnd   = (VW+1)'(v_c) + HALF;
        sh    = rnd >> (2*FRAC_W);
        dat_c = (|sh[VW:16]) ? 16'hFFFF : sh[15:0];
    end

    // Read -> horizontal blend -> vertical blend/round; coordinates ride along.
    always_ff @(posedge vin_clk) begin
        if (clr) begin
            v1 <= 1'b0; v2 <= 1'b0;
            vout_wr_valid <= 1'b0;
            vout_wr_x <= '0; vout_wr_y <= '0; vout_wr_dat <= '0;
        end else begin
            v1  <= (state == CALC);
            p00 <= top_mem[ix[AW-1:0]];
            p01 <= top_mem[ix1];
            p10 <= bot_mem[ix[AW-1:0]];
            p11 <= bot_mem[ix1];
            fx1 <= fx; fy1 <= fy; x1 <= ox; y1 <= oy;
            v2  <= v1;
            h0  <= h0_c; h1 <= h1_c; fy2 <= fy1; x2 <= x1; y2 <= y1;
            vout_wr_valid <= v2;
            if (v2) begin
                vout_wr_x   <= x2;
                vout_wr_y   <= y2;
                vout_wr_dat <= dat_c;
            end
        end
    end
endmodule

// File: tb/tb_bilinear_scale_down.sv
// Bench for bilinear_scale_down: DDR line-pair responder, expected-pixel scoreboard,
// fetch-sequence checks, frame abort and idle behaviour.
module tb_bilinear_scale_down;
    logic        clk = 1'b0;
    logic        rst_n, frame_sync_n, ddr_ready, wr_ram_en, fetch_done;
    logic [15:0] vin_xres, vin_yres, vout_xres, vout_yres, ram_dat;
    logic        fetch_en, vout_wr_valid;
    logic [15:0] fetch_line, vout_wr_x, vout_wr_y, vout_wr_dat;

    logic [47:0] exp_q[$];
    int          fetch_log[$];
    int          exp_fetch[$];
    int          n_tests = 0, n_fail = 0, n_out = 0;
    logic [15:0] src [0:7][0:7];
    int          cur_xr = 4, cur_yr = 4, cur_oxr = 1, cur_oyr = 1;
    bit          resp_busy = 1'b0;
    logic [47:0] e;

    always #5 clk = ~clk;

    bilinear_scale_down dut (
        .vin_clk(clk), .rst_n(rst_n), .frame_sync_n(frame_sync_n),
        .vin_xres(vin_xres), .vin_yres(vin_yres),
        .vout_xres(vout_xres), .vout_yres(vout_yres),
        .ddr_ready(ddr_ready), .fetch_en(fetch_en), .fetch_line(fetch_line),
        .wr_ram_en(wr_ram_en), .ram_dat(ram_dat), .fetch_done(fetch_done),
        .vout_wr_valid(vout_wr_valid), .vout_wr_x(vout_wr_x),
        .vout_wr_y(vout_wr_y), .vout_wr_dat(vout_wr_dat)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (vout_wr_valid) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", vout_wr_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("pixel_xyd", {vout_wr_x, vout_wr_y, vout_wr_dat}, e);
            end
        end
    end

    // DDR responder: streams the requested line pair with random gaps
    initial begin
        wr_ram_en = 1'b0; fetch_done = 1'b0; ram_dat = '0;
        forever begin
            @(negedge clk);
            if (fetch_en) begin
                int line;
                line = int'(fetch_line);
                fetch_log.push_back(line);
                resp_busy = 1'b1;
                @(negedge clk);
                for (int k = 0; k < 2 * cur_xr; k++) begin
                    while ($urandom_range(0, 3) == 0) @(negedge clk);
                    wr_ram_en = 1'b1;
                    ram_dat = (line + k / cur_xr < 8) ? src[line + k / cur_xr][k % cur_xr] : 16'h0;
                    @(negedge clk);
                    wr_ram_en = 1'b0;
                end
                fetch_done = 1'b1;
                @(negedge clk);
                fetch_done = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    function automatic logic [15:0] ref_pix(input int ox, input int oy);
        longint rx, ry, sx, sy, h0, h1, v, d;
        int ix, ix1, iy, fx, fy;
        logic [15:0] r;
        rx = (longint'(cur_xr) << 16) / cur_oxr;
        ry = (longint'(cur_yr) << 16) / cur_oyr;
        sx = ox * rx;
        sy = oy * ry;
        ix = int'(sx >> 16);
        fx = int'((sx >> 8) & 255);
        if (ix > cur_xr - 1) ix = cur_xr - 1;
        ix1 = (ix + 1 > cur_xr - 1) ? cur_xr - 1 : ix + 1;
        iy = int'(sy >> 16);
        fy = int'((sy >> 8) & 255);
        if (iy > cur_yr - 2) begin
            iy = cur_yr - 2;
            fy = 255;
        end
        h0 = longint'(src[iy][ix]) * (256 - fx) + longint'(src[iy][ix1]) * fx;
        h1 = longint'(src[iy+1][ix]) * (256 - fx) + longint'(src[iy+1][ix1]) * fx;
        v  = h0 * (256 - fy) + h1 * fy;
        d  = (v + 32768) >> 16;
        if (d > 65535) d = 65535;
        r = d[15:0];
        return r;
    endfunction

    task automatic push_model();
        for (int oy = 0; oy < cur_oyr; oy++)
            for (int ox = 0; ox < cur_oxr; ox++)
                exp_q.push_back({16'(ox), 16'(oy), ref_pix(ox, oy)});
    endtask

    task automatic model_fetch();
        longint ry;
        int iy, last;
        ry = (longint'(cur_yr) << 16) / cur_oyr;
        last = -1;
        exp_fetch.delete();
        for (int oy = 0; oy < cur_oyr; oy++) begin
            iy = int'((oy * ry) >> 16);
            if (iy > cur_yr - 2) iy = cur_yr - 2;
            if (iy != last) exp_fetch.push_back(iy);
            last = iy;
        end
    endtask

    task automatic set_frame(input int xr, input int yr, input int oxr, input int oyr);
        cur_xr = xr; cur_yr = yr; cur_oxr = oxr; cur_oyr = oyr;
        vin_xres = 16'(xr); vin_yres = 16'(yr);
        vout_xres = 16'(oxr); vout_yres = 16'(oyr);
    endtask

    task automatic start_frame();
        for (int i = 0; i < 500 && resp_busy; i++) @(negedge clk);
        fetch_log.delete();
        @(negedge clk) ddr_ready = 1'b1;
        @(negedge clk) ddr_ready = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 4000 && (exp_q.size() != 0 || resp_busy); i++) @(negedge clk);
        repeat (8) @(negedge clk);
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_nfetch"}, fetch_log.size(), exp_fetch.size());
        for (int i = 0; i < exp_fetch.size(); i++)
            check({tag, "_fetch_line"}, (i < fetch_log.size()) ? fetch_log[i] : -1, exp_fetch[i]);
        exp_q.delete();
    endtask

    task automatic fill_random(input int xr, input int yr);
        for (int y = 0; y < yr; y++)
            for (int x = 0; x < xr; x++)
                src[y][x] = 16'($urandom_range(0, 65535));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r2[8] = '{0, 8, 16, 24, 32, 40, 48, 48};
        int n_fe, n_v, snap;
        rst_n = 1'b0; frame_sync_n = 1'b1; ddr_ready = 1'b0;
        set_frame(4, 4, 8, 8);
        repeat (4) @(negedge clk);
        check("rst_valid", vout_wr_valid, 1'b0);
        check("rst_x", vout_wr_x, 16'h0);
        check("rst_y", vout_wr_y, 16'h0);
        check("rst_dat", vout_wr_dat, 16'h0);
        check("rst_fetch_en", fetch_en, 1'b0);
        check("rst_fetch_line", fetch_line, 16'h0);
        rst_n = 1'b1;

        // No ddr_ready: nothing must happen
        n_fe = 0; n_v = 0;
        repeat (50) begin
            @(negedge clk);
            if (fetch_en) n_fe++;
            if (vout_wr_valid) n_v++;
        end
        check("idle_fetch_en", n_fe, 0);
        check("idle_valid", n_v, 0);

        // Constant 15 upscale
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) src[y][x] = 16'd15;
        set_frame(4, 4, 8, 8);
        for (int oy = 0; oy < 8; oy++) for (int ox = 0; ox < 8; ox++)
            exp_q.push_back({16'(ox), 16'(oy), 16'd15});
        exp_fetch.delete(); exp_fetch.push_back(0); exp_fetch.push_back(1); exp_fetch.push_back(2);
        start_frame();
        wait_frame("const15");

        // Horizontal ramp: half-weight odd pixels and right-edge clamp
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) src[y][x] = 16'(x * 16);
        for (int oy = 0; oy < 8; oy++) for (int ox = 0; ox < 8; ox++)
            exp_q.push_back({16'(ox), 16'(oy), 16'(r2[ox])});
        start_frame();
        wait_frame("xramp");

        // Vertical ramp downscale 8x8 -> 4x4
        for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) src[y][x] = 16'(y * 10);
        set_frame(8, 8, 4, 4);
        for (int oy = 0; oy < 4; oy++) for (int ox = 0; ox < 4; ox++)
            exp_q.push_back({16'(ox), 16'(oy), 16'(oy * 20)});
        exp_fetch.delete();
        for (int i = 0; i < 4; i++) exp_fetch.push_back(2 * i);
        start_frame();
        wait_frame("yramp_down");

        // Random upscale with pair reuse
        fill_random(4, 4);
        set_frame(4, 4, 8, 8);
        push_model();
        exp_fetch.delete(); exp_fetch.push_back(0); exp_fetch.push_back(1); exp_fetch.push_back(2);
        start_frame();
        wait_frame("rand_up");

        // Odd ratios
        fill_random(7, 5);
        set_frame(7, 5, 3, 4);
        push_model(); model_fetch();
        start_frame();
        wait_frame("rand_7x5_3x4");
        fill_random(5, 6);
        set_frame(5, 6, 9, 3);
        push_model(); model_fetch();
        start_frame();
        wait_frame("rand_5x6_9x3");

        // Frame restart mid-CALC, then a full clean frame
        fill_random(4, 4);
        set_frame(4, 4, 8, 8);
        push_model();
        snap = n_out;
        start_frame();
        for (int i = 0; i < 2000 && n_out < snap + 10; i++) @(negedge clk);
        check("abort_reached_calc", (n_out >= snap + 10), 1'b1);
        frame_sync_n = 1'b0;
        @(negedge clk);
        check("abort_valid", vout_wr_valid, 1'b0);
        check("abort_x", vout_wr_x, 16'h0);
        check("abort_y", vout_wr_y, 16'h0);
        check("abort_dat", vout_wr_dat, 16'h0);
        check("abort_fetch_en", fetch_en, 1'b0);
        frame_sync_n = 1'b1;
        exp_q.delete();
        snap = n_out;
        repeat (40) @(negedge clk);
        check("abort_no_valid", n_out, snap);
        push_model();
        exp_fetch.delete(); exp_fetch.push_back(0); exp_fetch.push_back(1); exp_fetch.push_back(2);
        start_frame();
        wait_frame("resync");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
